// File: rtl/fft_frame_ctrl_if.sv
// Config and sample streams between the frame controller and the FFT core.
// Both streams use the usual valid/ready handshake.
interface fft_frame_ctrl_if #(
  parameter int TDATA_W = 16
) ();
  logic [7:0]           cfg_tdata;
  logic                 cfg_tvalid;
  logic                 cfg_tready;
  logic [2*TDATA_W-1:0] s_tdata;
  logic                 s_tvalid;
  logic                 s_tready;
  logic                 s_tlast;

  modport master (
    output cfg_tdata,
    output cfg_tvalid,
    input  cfg_tready,
    output s_tdata,
    output s_tvalid,
    output s_tlast,
    input  s_tready
  );

  modport slave (
    input  cfg_tdata,
    input  cfg_tvalid,
    output cfg_tready,
    input  s_tdata,
    input  s_tvalid,
    input  s_tlast,
    output s_tready
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frames ADC samples into N-point FFT input bursts through a small FIFO.
// Issues the direction config word whenever the mode changes.
module fft_frame_ctrl #(
  parameter int DATA_W     = 10,
  parameter int TDATA_W    = 16,
  parameter int FRAME_LOG2 = 10,
  parameter int FIFO_LOG2  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_valid,
  input  logic              fft_mode,
  input  logic              start,
  input  logic              continuous,
  input  logic              overflow_clr,
  fft_frame_ctrl_if.master  axis,
  output logic              busy,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  localparam int D = 2**FIFO_LOG2;

  typedef enum logic [1:0] {
    CFG,
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;

  logic                  mode_q;
  logic [7:0]            cfg_data;
  logic                  cfg_vld;
  logic [FRAME_LOG2-1:0] cnt;

  logic [TDATA_W:0]     mem [D];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   used;

  logic signed [DATA_W-1:0] samp;
  logic [TDATA_W-1:0]       re;
  logic empty, full, rd;
  logic wr_req, wr, last_wr;
  logic head_last, tlast_hs;

  // Offset-binary to two's complement: flip the MSB, then sign-extend.
  assign samp = {~ad_data[DATA_W-1], ad_data[DATA_W-2:0]};
  assign re   = TDATA_W'(samp);

  assign empty     = (used == '0);
  assign full      = (used == (FIFO_LOG2+1)'(D));
  assign rd        = !empty && axis.s_tready;
  assign wr_req    = (state == RUN) && ad_valid;
  assign wr        = wr_req && (!full || rd);
  assign last_wr   = wr && (&cnt);
  assign head_last = mem[rd_ptr][TDATA_W];
  assign tlast_hs  = rd && head_last;

  assign axis.s_tvalid = !empty;
  assign axis.s_tlast  = !empty && head_last;
  assign axis.s_tdata  = empty ? '0 :
    {{TDATA_W{1'b0}}, mem[rd_ptr][TDATA_W-1:0]};

  assign axis.cfg_tdata  = cfg_data;
  assign axis.cfg_tvalid = cfg_vld;

  always_ff @(posedge sys_clk) begin
    if (wr) mem[wr_ptr] <= {last_wr, re};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow <= 1'b0;
    end else if (wr_req && full && !rd) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= CFG;
      mode_q    <= 1'b1;
      cfg_data  <= '0;
      cfg_vld   <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        CFG: begin
          busy <= 1'b1;
          if (cfg_vld && axis.cfg_tready) begin
            cfg_vld <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            cfg_vld  <= 1'b1;
            cfg_data <= {7'b0, mode_q};
          end
        end
        IDLE: begin
          if (fft_mode != mode_q) begin
            mode_q   <= fft_mode;
            cfg_data <= {7'b0, fft_mode};
            cfg_vld  <= 1'b1;
            busy     <= 1'b1;
            state    <= CFG;
          end else if (start || continuous) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (wr) cnt <= cnt + 1'b1;
          if (last_wr) state <= DRAIN;
        end
        DRAIN: begin
          if (tlast_hs) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (fft_mode != mode_q) begin
              mode_q   <= fft_mode;
              cfg_data <= {7'b0, fft_mode};
              cfg_vld  <= 1'b1;
              state    <= CFG;
            end else if (continuous) begin
              cnt   <= '0;
              state <= RUN;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with N=8 and a 4-deep FIFO.
// Output beats are captured at the falling edge into a queue.
module tb_fft_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ad_data = '0;
  logic       ad_valid = 1'b0;
  logic       fft_mode = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       busy, overflow;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [32:0] q[$];
  logic [31:0] hold;

  fft_frame_ctrl_if #(.TDATA_W(16)) axis ();

  fft_frame_ctrl #(
    .DATA_W(10), .TDATA_W(16),
    .FRAME_LOG2(3), .FIFO_LOG2(2)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .ad_data(ad_data),
    .ad_valid(ad_valid),
    .fft_mode(fft_mode),
    .start(start),
    .continuous(continuous),
    .overflow_clr(overflow_clr),
    .axis(axis),
    .busy(busy),
    .overflow(overflow),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (axis.s_tvalid && axis.s_tready)
      q.push_back({axis.s_tlast, axis.s_tdata});
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [9:0] d);
    ad_valid = 1'b1;
    ad_data  = d;
    tick();
    ad_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk(tag, busy, 0);
  endtask

  task automatic chk_frame(input string tag,
                           input logic [15:0] base0,
                           input logic [15:0] base1);
    chk({tag, "_n"}, q.size(), 8);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      chk({tag, "_dat"}, q[i][31:0],
          (i < 4) ? 32'(base0 + 16'(i)) : 32'(base1 + 16'(i - 4)));
      chk({tag, "_last"}, q[i][32], i == 7);
    end
  endtask

  initial begin
    axis.cfg_tready = 1'b0;
    axis.s_tready   = 1'b1;

    // reset values
    tick();
    tick();
    chk("rst_cfgv", axis.cfg_tvalid, 0);
    chk("rst_cfgd", axis.cfg_tdata, 0);
    chk("rst_sv", axis.s_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fcnt", frame_cnt, 0);

    // config after reset, held under cfg_tready=0
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cfg_v", axis.cfg_tvalid, 1);
      chk("cfg_d", axis.cfg_tdata, 8'h01);
    end
    axis.cfg_tready = 1'b1;
    tick();
    chk("cfg_drop", axis.cfg_tvalid, 0);
    chk("cfg_idle", busy, 0);

    // single frame
    q.delete();
    pulse_start();
    chk("run_busy", busy, 1);
    for (int i = 0; i < 8; i++) feed(10'h200 + 10'(i));
    wait_idle("f1_idle");
    chk_frame("f1", 16'h0000, 16'h0004);
    chk("f1_fcnt", frame_cnt, 1);

    // sign mapping
    q.delete();
    pulse_start();
    feed(10'h000);
    feed(10'h3FF);
    for (int i = 0; i < 6; i++) feed(10'h200);
    wait_idle("sg_idle");
    chk("sg_n", q.size(), 8);
    chk("sg_neg", q[0][31:0], 32'h0000FE00);
    chk("sg_pos", q[1][31:0], 32'h000001FF);
    chk("sg_fcnt", frame_cnt, 2);

    // ad_valid outside RUN is ignored
    q.delete();
    for (int i = 0; i < 6; i++) feed(10'h123);
    chk("idl_ovf", overflow, 0);
    chk("idl_n", q.size(), 0);

    // backpressure and overflow
    axis.s_tready = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) feed(10'h210 + 10'(i));
    chk("bp_ovf", overflow, 1);
    chk("bp_sv", axis.s_tvalid, 1);
    hold = axis.s_tdata;
    chk("bp_head", hold, 32'h10);
    tick();
    tick();
    chk("bp_stable", axis.s_tdata, hold);
    chk("bp_n0", q.size(), 0);
    axis.s_tready = 1'b1;
    for (int i = 0; i < 4; i++) feed(10'h216 + 10'(i));
    wait_idle("bp_idle");
    chk_frame("bp", 16'h0010, 16'h0016);
    chk("bp_fcnt", frame_cnt, 3);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // mode change in continuous operation
    q.delete();
    axis.cfg_tready = 1'b0;
    continuous = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) feed(10'h220 + 10'(i));
    fft_mode = 1'b0;
    for (int i = 3; i < 8; i++) feed(10'h220 + 10'(i));
    for (int i = 0; i < 40 && !axis.cfg_tvalid; i++) tick();
    chk("mc_cfgv", axis.cfg_tvalid, 1);
    chk("mc_cfgd", axis.cfg_tdata, 8'h00);
    chk("mc_fcnt", frame_cnt, 4);
    chk_frame("mc", 16'h0020, 16'h0024);
    q.delete();
    axis.cfg_tready = 1'b1;
    tick();
    tick();
    tick();
    chk("mc_run", busy, 1);
    for (int i = 0; i < 8; i++) feed(10'h230 + 10'(i));
    continuous = 1'b0;
    wait_idle("mc2_idle");
    chk_frame("mc2", 16'h0030, 16'h0034);
    chk("mc2_fcnt", frame_cnt, 5);

    // reset mid-frame
    q.delete();
    axis.s_tready = 1'b0;
    axis.cfg_tready = 1'b0;
    pulse_start();
    for (int i = 0; i < 3; i++) feed(10'h240 + 10'(i));
    chk("mr_pre", axis.s_tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mr_sv", axis.s_tvalid, 0);
    chk("mr_last", axis.s_tlast, 0);
    chk("mr_busy", busy, 0);
    chk("mr_fcnt", frame_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_cfgv", axis.cfg_tvalid, 1);
    chk("mr_cfgd", axis.cfg_tdata, 8'h01);
    axis.cfg_tready = 1'b1;
    axis.s_tready = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("mr_n", q.size(), 0);
    chk("mr_sv2", axis.s_tvalid, 0);
    chk("mr_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
